// File: rtl/neuron_train_sequencer.sv
// neuron_train_sequencer: feeds training samples to one neuron and pulses its commit clock.
// Optional: define TS_EARLY_STOP_EN to end a run early on a low epoch error sum.
module neuron_train_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PROP_CYCLES   = 1,
    parameter int EPOCH_W       = 16
) (
    input  logic               ts_clock,
    input  logic               ts_reset_n,
    input  logic               ts_start,
    input  logic [EPOCH_W-1:0] ts_cfg_epochs,
    input  real                ts_cfg_ratio,
    input  logic [31:0]        ts_cfg_enabled,
`ifdef TS_EARLY_STOP_EN
    input  real                ts_cfg_err_thresh,
`endif
    input  logic               ts_sample_valid,
    output logic               ts_sample_ready,
    input  real                ts_sample_data [31:0],
    input  real                ts_sample_target,
    input  logic               ts_sample_last,
    input  real                ts_axon,
    output real                ts_dendrites [31:0],
    output logic [31:0]        ts_enabled,
    output real                ts_backprop,
    output real                ts_training_ratio,
    output logic               ts_neuron_clock,
    output logic               ts_busy,
    output logic               ts_done,
    output logic [EPOCH_W-1:0] ts_epoch_count,
    output logic [EPOCH_W-1:0] ts_sample_count,
    output real                ts_err_sq_sum
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_PROP    = 3'd4;
    localparam logic [2:0] S_COMMIT  = 3'd5;
    localparam logic [2:0] S_RELEASE = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    localparam int WAIT_W = 16;

    logic [2:0]         state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [EPOCH_W-1:0] cfg_epochs;
    logic [EPOCH_W-1:0] epoch_nxt;
    logic               last_q;
    logic               stop;
    real                target_q;
    real                err;
`ifdef TS_EARLY_STOP_EN
    real                thresh_q;
`endif

    assign ts_sample_ready = (state == S_FETCH);
    // Commit clock is high for the COMMIT cycle; it falls as RELEASE begins,
    // while backprop still holds the captured error.
    assign ts_neuron_clock = (state == S_COMMIT);
    assign ts_done         = (state == S_DONE);
    assign ts_busy         = (state != S_IDLE) && (state != S_DONE);
    assign epoch_nxt       = ts_epoch_count + EPOCH_W'(1);

    always_comb begin
        err  = target_q - ts_axon;
        stop = (epoch_nxt == cfg_epochs);
`ifdef TS_EARLY_STOP_EN
        if (ts_err_sq_sum <= thresh_q)
            stop = 1'b1;
`endif
    end

    always_ff @(posedge ts_clock or negedge ts_reset_n) begin
        if (!ts_reset_n) begin
            state             <= S_IDLE;
            wait_cnt          <= '0;
            cfg_epochs        <= '0;
            last_q            <= 1'b0;
            target_q          <= 0.0;
`ifdef TS_EARLY_STOP_EN
            thresh_q          <= 0.0;
`endif
            ts_enabled        <= '0;
            ts_backprop       <= 0.0;
            ts_training_ratio <= 0.0;
            ts_epoch_count    <= '0;
            ts_sample_count   <= '0;
            ts_err_sq_sum     <= 0.0;
            for (int i = 0; i < 32; i++)
                ts_dendrites[i] <= 0.0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (ts_start) begin
                        cfg_epochs        <= ts_cfg_epochs;
                        ts_training_ratio <= ts_cfg_ratio;
                        ts_enabled        <= ts_cfg_enabled;
`ifdef TS_EARLY_STOP_EN
                        thresh_q          <= ts_cfg_err_thresh;
`endif
                        ts_epoch_count    <= '0;
                        ts_sample_count   <= '0;
                        ts_err_sq_sum     <= 0.0;
                        state <= (ts_cfg_epochs == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (ts_sample_valid) begin
                        for (int i = 0; i < 32; i++)
                            ts_dendrites[i] <= ts_sample_data[i];
                        target_q <= ts_sample_target;
                        last_q   <= ts_sample_last;
                        wait_cnt <= WAIT_W'(SETTLE_CYCLES - 1);
                        state    <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (wait_cnt == '0)
                        state <= S_CAPTURE;
                    else
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                end
                S_CAPTURE: begin
                    ts_backprop   <= err;
                    ts_err_sq_sum <= ts_err_sq_sum + err * err;
                    wait_cnt      <= WAIT_W'(PROP_CYCLES - 1);
                    state         <= S_PROP;
                end
                S_PROP: begin
                    if (wait_cnt == '0)
                        state <= S_COMMIT;
                    else
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                end
                S_COMMIT: begin
                    state <= S_RELEASE;
                end
                S_RELEASE: begin
                    ts_backprop <= 0.0;
                    if (last_q) begin
                        ts_epoch_count  <= epoch_nxt;
                        ts_sample_count <= '0;
                        if (stop) begin
                            state <= S_DONE;
                        end else begin
                            ts_err_sq_sum <= 0.0;
                            state         <= S_FETCH;
                        end
                    end else begin
                        ts_sample_count <= ts_sample_count + EPOCH_W'(1);
                        state           <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_train_sequencer.sv
// Directed bench for neuron_train_sequencer: timing, error math, handshake, reset.
// Covers the TS_EARLY_STOP_EN path when that macro is defined.
module tb_neuron_train_sequencer;

    localparam int EW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [EW-1:0] cfg_epochs = '0;
    real           cfg_ratio = 0.0;
    logic [31:0]   cfg_enabled = '0;
`ifdef TS_EARLY_STOP_EN
    real           cfg_thresh = 0.0;
`endif
    logic          valid = 1'b0;
    logic          ready;
    real           sdata [31:0];
    real           target = 1.0;
    logic          slast = 1'b0;
    real           axon = 0.25;
    real           dend [31:0];
    logic [31:0]   enabled;
    real           backprop;
    real           ratio;
    logic          nclk;
    logic          busy;
    logic          done;
    logic [EW-1:0] epoch_cnt;
    logic [EW-1:0] sample_cnt;
    real           err_sum;

    int total = 0;
    int bad = 0;
    int edges = 0;
    int ready_viol = 0;
    int acc_q[$];

    neuron_train_sequencer #(
        .SETTLE_CYCLES(2),
        .PROP_CYCLES(1),
        .EPOCH_W(EW)
    ) dut (
        .ts_clock(clk),
        .ts_reset_n(rst_n),
        .ts_start(start),
        .ts_cfg_epochs(cfg_epochs),
        .ts_cfg_ratio(cfg_ratio),
        .ts_cfg_enabled(cfg_enabled),
`ifdef TS_EARLY_STOP_EN
        .ts_cfg_err_thresh(cfg_thresh),
`endif
        .ts_sample_valid(valid),
        .ts_sample_ready(ready),
        .ts_sample_data(sdata),
        .ts_sample_target(target),
        .ts_sample_last(slast),
        .ts_axon(axon),
        .ts_dendrites(dend),
        .ts_enabled(enabled),
        .ts_backprop(backprop),
        .ts_training_ratio(ratio),
        .ts_neuron_clock(nclk),
        .ts_busy(busy),
        .ts_done(done),
        .ts_epoch_count(epoch_cnt),
        .ts_sample_count(sample_cnt),
        .ts_err_sq_sum(err_sum)
    );

    always #5 clk = ~clk;

    always @(negedge nclk) edges++;

    always @(posedge clk)
        if (valid && ready)
            acc_q.push_back(int'(sdata[0]));

    always @(negedge clk)
        if (rst_n && ready && (!busy || nclk || backprop != 0.0))
            ready_viol++;

    task automatic pulse_start(input int ep, input real r, input logic [31:0] en);
        @(negedge clk);
        cfg_epochs  = EW'(ep);
        cfg_ratio   = r;
        cfg_enabled = en;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns just after the accepting posedge.
    task automatic send(input int tag, input bit last, input int gap);
        int n;
        valid = 1'b0;
        repeat (gap) @(negedge clk);
        for (int i = 0; i < 32; i++)
            sdata[i] = real'(tag) + real'(i) * 1000.0;
        slast = last;
        valid = 1'b1;
        n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 100) begin
            bad++;
            $display("FAIL send_timeout tag=%0d: ready never seen", tag);
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
        slast = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({busy, done, ready, nclk} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 0000", {busy, done, ready, nclk});
        end
        total++;
        if (epoch_cnt !== '0 || sample_cnt !== '0 || enabled !== '0) begin
            bad++;
            $display("FAIL reset_counts: ep=%0d sc=%0d en=%h want 0", epoch_cnt, sample_cnt, enabled);
        end
        total++;
        if (backprop != 0.0 || ratio != 0.0 || err_sum != 0.0 || dend[7] != 0.0) begin
            bad++;
            $display("FAIL reset_reals: bp=%f r=%f e=%f d=%f want 0", backprop, ratio, err_sum, dend[7]);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, done, ready} !== 3'b000) begin
            bad++;
            $display("FAIL idle_hold: got %b want 000", {busy, done, ready});
        end
    endtask

    task automatic test_zero_epochs();
        edges = 0;
        pulse_start(0, 0.5, 32'h1234_5678);
        total++;
        if ({done, busy, ready} !== 3'b100) begin
            bad++;
            $display("FAIL zero_ep_done: got %b want 100", {done, busy, ready});
        end
        repeat (3) @(negedge clk);
        total++;
        if (edges != 0 || epoch_cnt !== '0 || enabled !== 32'h1234_5678) begin
            bad++;
            $display("FAIL zero_ep_state: edges=%0d ep=%0d en=%h want 0 0 12345678", edges, epoch_cnt, enabled);
        end
    endtask

    task automatic test_two_epochs();
        int n;
        edges = 0;
        axon = 0.25;
        target = 1.0;
        pulse_start(2, 0.5, 32'hA5A5_0F0F);
        send(1, 1'b0, 0);
        repeat (3) @(negedge clk);
        total++;
        if (backprop != 0.0 || !busy) begin
            bad++;
            $display("FAIL capture_bp: bp=%f busy=%b want 0.0 1", backprop, busy);
        end
        @(negedge clk);
        total++;
        if (backprop != 0.75 || err_sum != 0.5625) begin
            bad++;
            $display("FAIL prop_err: bp=%f e=%f want 0.75 0.5625", backprop, err_sum);
        end
        total++;
        if (enabled !== 32'hA5A5_0F0F || ratio != 0.5 || dend[5] != 5001.0) begin
            bad++;
            $display("FAIL drive_vals: en=%h r=%f d5=%f", enabled, ratio, dend[5]);
        end
        @(negedge clk);
        total++;
        if (nclk !== 1'b1 || backprop != 0.75) begin
            bad++;
            $display("FAIL commit_clk: nclk=%b bp=%f want 1 0.75", nclk, backprop);
        end
        @(negedge clk);
        total++;
        if (nclk !== 1'b0 || edges != 1 || sample_cnt !== 16'd0) begin
            bad++;
            $display("FAIL release: nclk=%b edges=%0d sc=%0d want 0 1 0", nclk, edges, sample_cnt);
        end
        @(negedge clk);
        total++;
        if (ready !== 1'b1 || sample_cnt !== 16'd1 || backprop != 0.0) begin
            bad++;
            $display("FAIL refetch: rdy=%b sc=%0d bp=%f want 1 1 0.0", ready, sample_cnt, backprop);
        end
        send(2, 1'b0, 0);
        @(negedge clk);
        cfg_epochs = 16'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send(3, 1'b1, 0);
        n = 0;
        while (nclk !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (err_sum != 1.6875 || sample_cnt !== 16'd2) begin
            bad++;
            $display("FAIL epoch_err: e=%f sc=%0d want 1.6875 2", err_sum, sample_cnt);
        end
        repeat (2) @(negedge clk);
        total++;
        if (epoch_cnt !== 16'd1 || sample_cnt !== 16'd0 || err_sum != 0.0 || !busy) begin
            bad++;
            $display("FAIL epoch1: ep=%0d sc=%0d e=%f busy=%b want 1 0 0.0 1", epoch_cnt, sample_cnt, err_sum, busy);
        end
        send(4, 1'b0, 0);
        send(5, 1'b0, 1);
        send(6, 1'b1, 0);
        wait_done();
        total++;
        if ({done, busy} !== 2'b10 || epoch_cnt !== 16'd2 || edges != 6) begin
            bad++;
            $display("FAIL run_end: done/busy=%b ep=%0d edges=%0d want 10 2 6", {done, busy}, epoch_cnt, edges);
        end
        total++;
        if (err_sum != 1.6875 || dend[0] != 6.0 || enabled !== 32'hA5A5_0F0F || ratio != 0.5) begin
            bad++;
            $display("FAIL done_hold: e=%f d0=%f en=%h r=%f", err_sum, dend[0], enabled, ratio);
        end
    endtask

    task automatic test_valid_gaps();
        pulse_start(1, 0.25, 32'hFFFF_FFFF);
        acc_q.delete();
        edges = 0;
        ready_viol = 0;
        for (int t = 0; t < 5; t++) begin
            send(10 + t, t == 4, int'($urandom_range(0, 8)));
            @(negedge clk);
            total++;
            if (dend[0] != real'(10 + t) || dend[31] != real'(10 + t) + 31000.0) begin
                bad++;
                $display("FAIL gap_data t=%0d: d0=%f d31=%f", t, dend[0], dend[31]);
            end
        end
        wait_done();
        total++;
        if (acc_q.size() != 5 || edges != 5 || ready_viol != 0 || epoch_cnt !== 16'd1) begin
            bad++;
            $display("FAIL gap_totals: acc=%0d edges=%0d viol=%0d ep=%0d want 5 5 0 1", acc_q.size(), edges, ready_viol, epoch_cnt);
        end
        for (int t = 0; t < acc_q.size(); t++) begin
            total++;
            if (acc_q[t] != 10 + t) begin
                bad++;
                $display("FAIL gap_tag %0d: got %0d want %0d", t, acc_q[t], 10 + t);
            end
        end
    endtask

    task automatic test_reset_mid();
        edges = 0;
        pulse_start(2, 0.5, 32'hFFFF_0000);
        send(20, 1'b0, 0);
        send(21, 1'b0, 0);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, ready, nclk} !== 4'b0000 || epoch_cnt !== '0 || sample_cnt !== '0 || enabled !== '0) begin
            bad++;
            $display("FAIL mid_reset_logic: flags=%b sc=%0d en=%h", {busy, done, ready, nclk}, sample_cnt, enabled);
        end
        total++;
        if (backprop != 0.0 || err_sum != 0.0 || ratio != 0.0 || dend[0] != 0.0 || edges != 1) begin
            bad++;
            $display("FAIL mid_reset_reals: bp=%f e=%f r=%f d0=%f edges=%0d", backprop, err_sum, ratio, dend[0], edges);
        end
        @(negedge clk);
        rst_n = 1'b1;
        edges = 0;
        acc_q.delete();
        pulse_start(1, 0.5, 32'h0000_00FF);
        send(30, 1'b0, 0);
        send(31, 1'b1, 0);
        wait_done();
        total++;
        if (!done || epoch_cnt !== 16'd1 || edges != 2 || err_sum != 1.125) begin
            bad++;
            $display("FAIL restart: done=%b ep=%0d edges=%0d e=%f want 1 1 2 1.125", done, epoch_cnt, edges, err_sum);
        end
        total++;
        if (acc_q.size() != 2 || acc_q[0] != 30 || acc_q[acc_q.size()-1] != 31) begin
            bad++;
            $display("FAIL restart_tags: n=%0d", acc_q.size());
        end
    endtask

`ifdef TS_EARLY_STOP_EN
    task automatic test_early_stop();
        edges = 0;
        cfg_thresh = 0.1;
        axon = 1.0;
        pulse_start(5, 0.5, 32'h0F0F_0F0F);
        send(40, 1'b0, 0);
        send(41, 1'b1, 0);
        wait_done();
        total++;
        if (!done || epoch_cnt !== 16'd1 || edges != 2 || err_sum != 0.0) begin
            bad++;
            $display("FAIL early_stop: done=%b ep=%0d edges=%0d e=%f want 1 1 2 0.0", done, epoch_cnt, edges, err_sum);
        end
        axon = 0.25;
    endtask
`endif

    initial begin
        for (int i = 0; i < 32; i++)
            sdata[i] = 0.0;
        test_reset();
        test_zero_epochs();
        test_two_epochs();
        test_valid_gaps();
        test_reset_mid();
`ifdef TS_EARLY_STOP_EN
        test_early_stop();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
